// File: rtl/ux607_qspi_xip_ncs.sv
`default_nettype none
// ============================================================================
// Module   : ux607_qspi_xip_ncs
// Purpose  : ICB-native QSPI flash read controller (execute-in-place) with
//            CS_NUM chip selects. It has a small CSR window (CTRL, STATUS),
//            a runtime-selectable single (0x03) or quad-output fast read
//            (0x6B) mode, and a programmable SCK divider. One transaction
//            is outstanding at a time, and only word reads reach flash.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            i_icb_cmd_*          ICB command channel (valid/ready/addr/read/wdata)
//            i_icb_rsp_*          ICB response channel (valid/ready/rdata/err)
//            io_port_sck          SPI clock, mode 0 (idle low)
//            io_port_dq_{0..3}_*  data pads (_i input, _o output, _oe enable)
//            io_port_cs           active-low chip selects, one per device
// Revision : 1.0 - initial release
// ============================================================================
module ux607_qspi_xip_ncs #(
    parameter int         ADDR_W      = 32,
    parameter int         CS_NUM      = 2,
    parameter int         CS_SEL_LSB  = 24,
    parameter int         CSR_SEL_BIT = 28,
    parameter logic [7:0] SCKDIV_RST  = 8'd3,
    parameter int         CSHI_CYC    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [ADDR_W-1:0] i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [31:0]       i_icb_cmd_wdata,
    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic [31:0]       i_icb_rsp_rdata,
    output logic              i_icb_rsp_err,
    output logic              io_port_sck,
    input  logic              io_port_dq_0_i,
    output logic              io_port_dq_0_o,
    output logic              io_port_dq_0_oe,
    input  logic              io_port_dq_1_i,
    output logic              io_port_dq_1_o,
    output logic              io_port_dq_1_oe,
    input  logic              io_port_dq_2_i,
    output logic              io_port_dq_2_o,
    output logic              io_port_dq_2_oe,
    input  logic              io_port_dq_3_i,
    output logic              io_port_dq_3_o,
    output logic              io_port_dq_3_oe,
    output logic [CS_NUM-1:0] io_port_cs
);

    localparam int         CS_W         = $clog2(CS_NUM);
    localparam int         CSHI_W       = (CSHI_CYC < 2) ? 1 : $clog2(CSHI_CYC + 1);
    localparam logic [7:0] c_CMD_SINGLE = 8'h03;
    localparam logic [7:0] c_CMD_QUAD   = 8'h6B;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_END   = 3'd5,
        S_RSP   = 3'd6
    } state_t;

    state_t              r_state_q,   w_state_d;
    logic                r_sck_q,     w_sck_d;
    logic [CS_NUM-1:0]   r_cs_q,      w_cs_d;
    logic [31:0]         r_tx_q,      w_tx_d;
    logic [31:0]         r_rx_q,      w_rx_d;
    logic                r_dq0_oe_q,  w_dq0_oe_d;
    logic                r_wphold_q,  w_wphold_d;
    logic [7:0]          r_div_cnt_q, w_div_cnt_d;
    logic [7:0]          r_div_q,     w_div_d;
    logic                r_quad_q,    w_quad_d;
    logic [6:0]          r_rise_q,    w_rise_d;
    logic [CSHI_W-1:0]   r_cshi_q,    w_cshi_d;
    logic                r_rsp_valid_q, w_rsp_valid_d;
    logic [31:0]         r_rsp_rdata_q, w_rsp_rdata_d;
    logic                r_rsp_err_q,   w_rsp_err_d;
    logic                r_ctrl_quad_q,   w_ctrl_quad_d;
    logic [7:0]          r_ctrl_sckdiv_q, w_ctrl_sckdiv_d;

    logic                w_accept;
    logic                w_is_csr;
    logic [1:0]          w_csr_off;
    logic [CS_W-1:0]     w_chip;
    logic [CS_NUM-1:0]   w_cs_sel;
    logic                w_tick;
    logic [6:0]          w_n_total;
    logic                w_unused;

    assign w_is_csr  = i_icb_cmd_addr[CSR_SEL_BIT];
    assign w_csr_off = i_icb_cmd_addr[3:2];
    assign w_chip    = i_icb_cmd_addr[CS_SEL_LSB +: CS_W];
    assign w_tick    = (r_div_cnt_q == r_div_q);
    assign w_n_total = r_quad_q ? 7'd48 : 7'd64;
    // Address/wdata bits outside the decoded fields are intentionally ignored.
    assign w_unused  = ^{i_icb_cmd_addr, i_icb_cmd_wdata};

    // Gap counter gates new commands so CS stays high long enough between transfers.
    assign i_icb_cmd_ready = (r_state_q == S_IDLE) && (r_cshi_q == '0);
    assign w_accept        = i_icb_cmd_valid && i_icb_cmd_ready;

    always_comb begin
        w_cs_sel         = '1;
        w_cs_sel[w_chip] = 1'b0;
    end

    always_comb begin
        w_state_d       = r_state_q;
        w_sck_d         = r_sck_q;
        w_cs_d          = r_cs_q;
        w_tx_d          = r_tx_q;
        w_rx_d          = r_rx_q;
        w_dq0_oe_d      = r_dq0_oe_q;
        w_wphold_d      = r_wphold_q;
        w_div_cnt_d     = r_div_cnt_q;
        w_div_d         = r_div_q;
        w_quad_d        = r_quad_q;
        w_rise_d        = r_rise_q;
        w_cshi_d        = (r_cshi_q != '0) ? (r_cshi_q - CSHI_W'(1)) : r_cshi_q;
        w_rsp_valid_d   = r_rsp_valid_q;
        w_rsp_rdata_d   = r_rsp_rdata_q;
        w_rsp_err_d     = r_rsp_err_q;
        w_ctrl_quad_d   = r_ctrl_quad_q;
        w_ctrl_sckdiv_d = r_ctrl_sckdiv_q;

        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_csr) begin
                        w_state_d     = S_RSP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b0;
                        w_rsp_rdata_d = 32'h0;
                        if (w_csr_off == 2'd0) begin
                            if (i_icb_cmd_read) begin
                                w_rsp_rdata_d = {16'h0, r_ctrl_sckdiv_q, 7'h0, r_ctrl_quad_q};
                            end else begin
                                w_ctrl_quad_d   = i_icb_cmd_wdata[0];
                                w_ctrl_sckdiv_d = i_icb_cmd_wdata[15:8];
                            end
                        end
                        // STATUS.busy reads 0: the bus only sees it while idle.
                    end else if (!i_icb_cmd_read) begin
                        w_state_d     = S_RSP;
                        w_rsp_valid_d = 1'b1;
                        w_rsp_err_d   = 1'b1;
                        w_rsp_rdata_d = 32'h0;
                    end else begin
                        w_state_d   = S_CMD;
                        w_cs_d      = w_cs_sel;
                        w_sck_d     = 1'b0;
                        w_div_cnt_d = 8'd0;
                        w_rise_d    = 7'd0;
                        w_div_d     = r_ctrl_sckdiv_q;
                        w_quad_d    = r_ctrl_quad_q;
                        w_tx_d      = {(r_ctrl_quad_q ? c_CMD_QUAD : c_CMD_SINGLE),
                                       i_icb_cmd_addr[23:2], 2'b00};
                        w_rx_d      = 32'h0;
                        w_dq0_oe_d  = 1'b1;
                        w_wphold_d  = 1'b1;
                    end
                end
            end

            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (w_tick) begin
                    w_div_cnt_d = 8'd0;
                    w_sck_d     = ~r_sck_q;
                    if (!r_sck_q) begin
                        // Rising edge: count it and capture read data.
                        w_rise_d = r_rise_q + 7'd1;
                        if (r_state_q == S_DATA) begin
                            w_rx_d = r_quad_q ?
                                {r_rx_q[27:0], io_port_dq_3_i, io_port_dq_2_i,
                                 io_port_dq_1_i, io_port_dq_0_i} :
                                {r_rx_q[30:0], io_port_dq_1_i};
                        end
                    end else begin
                        // Falling edge: advance the output bit and the phase.
                        w_tx_d = {r_tx_q[30:0], 1'b0};
                        if (r_rise_q == w_n_total) begin
                            w_cs_d     = '1;
                            w_dq0_oe_d = 1'b0;
                            w_wphold_d = 1'b0;
                            w_cshi_d   = CSHI_W'(CSHI_CYC);
                            w_state_d  = S_END;
                        end else if (r_rise_q == 7'd8) begin
                            w_state_d = S_ADDR;
                        end else if (r_rise_q == 7'd32) begin
                            w_dq0_oe_d = 1'b0;
                            if (r_quad_q) begin
                                w_state_d  = S_DUMMY;
                                w_wphold_d = 1'b0;
                            end else begin
                                w_state_d = S_DATA;
                            end
                        end else if ((r_rise_q == 7'd40) && (r_state_q == S_DUMMY)) begin
                            w_state_d = S_DATA;
                        end
                    end
                end else begin
                    w_div_cnt_d = r_div_cnt_q + 8'd1;
                end
            end

            S_END: begin
                // First flash byte arrived in the top byte; bus wants it at [7:0].
                w_state_d     = S_RSP;
                w_rsp_valid_d = 1'b1;
                w_rsp_err_d   = 1'b0;
                w_rsp_rdata_d = {r_rx_q[7:0], r_rx_q[15:8], r_rx_q[23:16], r_rx_q[31:24]};
            end

            S_RSP: begin
                if (i_icb_rsp_ready) begin
                    w_rsp_valid_d = 1'b0;
                    w_state_d     = S_IDLE;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q       <= S_IDLE;
            r_sck_q         <= 1'b0;
            r_cs_q          <= '1;
            r_tx_q          <= 32'h0;
            r_rx_q          <= 32'h0;
            r_dq0_oe_q      <= 1'b0;
            r_wphold_q      <= 1'b0;
            r_div_cnt_q     <= 8'd0;
            r_div_q         <= 8'd0;
            r_quad_q        <= 1'b0;
            r_rise_q        <= 7'd0;
            r_cshi_q        <= '0;
            r_rsp_valid_q   <= 1'b0;
            r_rsp_rdata_q   <= 32'h0;
            r_rsp_err_q     <= 1'b0;
            r_ctrl_quad_q   <= 1'b0;
            r_ctrl_sckdiv_q <= SCKDIV_RST;
        end else begin
            r_state_q       <= w_state_d;
            r_sck_q         <= w_sck_d;
            r_cs_q          <= w_cs_d;
            r_tx_q          <= w_tx_d;
            r_rx_q          <= w_rx_d;
            r_dq0_oe_q      <= w_dq0_oe_d;
            r_wphold_q      <= w_wphold_d;
            r_div_cnt_q     <= w_div_cnt_d;
            r_div_q         <= w_div_d;
            r_quad_q        <= w_quad_d;
            r_rise_q        <= w_rise_d;
            r_cshi_q        <= w_cshi_d;
            r_rsp_valid_q   <= w_rsp_valid_d;
            r_rsp_rdata_q   <= w_rsp_rdata_d;
            r_rsp_err_q     <= w_rsp_err_d;
            r_ctrl_quad_q   <= w_ctrl_quad_d;
            r_ctrl_sckdiv_q <= w_ctrl_sckdiv_d;
        end
    end

    assign i_icb_rsp_valid = r_rsp_valid_q;
    assign i_icb_rsp_rdata = r_rsp_rdata_q;
    assign i_icb_rsp_err   = r_rsp_err_q;
    assign io_port_sck     = r_sck_q;
    assign io_port_cs      = r_cs_q;
    // The shift register empties to zero once cmd/addr are out, so dq0 idles low.
    assign io_port_dq_0_o  = r_tx_q[31];
    assign io_port_dq_0_oe = r_dq0_oe_q;
    assign io_port_dq_1_o  = 1'b0;
    assign io_port_dq_1_oe = 1'b0;
    // WP#/HOLD# are held high while driven.
    assign io_port_dq_2_o  = r_wphold_q;
    assign io_port_dq_2_oe = r_wphold_q;
    assign io_port_dq_3_o  = r_wphold_q;
    assign io_port_dq_3_oe = r_wphold_q;

endmodule
`default_nettype wire
